// File: rtl/param_arb.sv
// N-way bus arbiter with run-time fixed-priority / round-robin selection and an
// optional maximum-hold timeout that pre-empts an owner holding the bus too long.
//
//   state | meaning
//   IDLE  | no owner, arbitrate every edge over all requests
//   OWNED | one-hot grant held by a single owner
module param_arb #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           mode,
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id,
  output logic           timeout
);

  // With the timeout disabled the counter only saturates; it never pre-empts.
  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HCW-1:0] HOLD_TOP = (MAX_HOLD > 0) ? HCW'(MAX_HOLD) : {HCW{1'b1}};

  typedef enum logic {IDLE, OWNED} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] last_q, last_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic           to_q, to_d;

  logic [N-1:0]   cand;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] rr_idx;
  logic           owner_req;
  logic           do_arb;

  assign owner_req = |(req & grant_q);

  // The current owner is masked out of the candidate set whenever it is
  // released or pre-empted; from IDLE every request is eligible.
  always_comb begin
    cand      = req;
    win_found = 1'b0;
    win_id    = '0;
    rr_idx    = '0;
    if (state_q == OWNED) cand = req & ~grant_q;
    if (!mode) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (cand[i]) begin
          win_found = 1'b1;
          win_id    = IDW'(i);
        end
      end
    end else begin
      // Walk distances from far to near so the nearest index after LAST wins.
      for (int j = N; j >= 1; j--) begin
        rr_idx = IDW'((int'(last_q) + j) % N);
        if (cand[rr_idx]) begin
          win_found = 1'b1;
          win_id    = rr_idx;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    last_d  = last_q;
    hold_d  = hold_q;
    to_d    = 1'b0;
    do_arb  = 1'b0;
    case (state_q)
      IDLE: do_arb = 1'b1;
      OWNED: begin
        if (!owner_req) begin
          do_arb = 1'b1;
        end else if ((MAX_HOLD != 0) && (hold_q == HOLD_TOP)) begin
          do_arb = 1'b1;
          to_d   = 1'b1;
        end else if (hold_q != HOLD_TOP) begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_arb) begin
      if (win_found) begin
        state_d         = OWNED;
        grant_d         = '0;
        grant_d[win_id] = 1'b1;
        id_d            = win_id;
        last_d          = win_id;
        hold_d          = HCW'(1);
      end else begin
        state_d = IDLE;
        grant_d = '0;
        id_d    = '0;
        hold_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      id_q    <= '0;
      last_q  <= IDW'(N - 1);
      hold_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = id_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_param_arb.sv
// Scoreboard bench for param_arb (N=8, MAX_HOLD=4): directed request patterns
// push expected grants; a negedge monitor pops and compares every presented output.
module tb_param_arb;
  localparam int N   = 8;
  localparam int MH  = 4;
  localparam int IDW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic           mode;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           timeout;

  always #5 clk = ~clk;

  param_arb #(.N(N), .MAX_HOLD(MH), .IDW(IDW)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .mode(mode),
    .grant(grant),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .timeout(timeout)
  );

  typedef struct packed {
    logic [N-1:0]   g;
    logic [IDW-1:0] id;
    logic           to;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  // One clock of stimulus; the expected output after this edge is queued
  // only when the DUT is expected to present something (grant or timeout).
  task automatic cyc(input logic [N-1:0] r, input logic m, input logic [N-1:0] eg,
                     input logic [IDW-1:0] eid, input logic et);
    req  = r;
    mode = m;
    @(posedge clk);
    if (eg != '0 || et) exp_q.push_back({eg, eid, et});
    #2;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && (grant_valid || timeout)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got grant=%0h timeout=%0b want nothing at %0t",
                 grant, timeout, $time);
      end else begin
        e = exp_q.pop_front();
        check("grant", int'(grant), int'(e.g));
        check("grant_id", int'(grant_id), int'(e.id));
        check("grant_valid", int'(grant_valid), int'(e.g != '0));
        check("timeout", int'(timeout), int'(e.to));
      end
    end
  end

  initial begin
    logic [N-1:0] r8;
    logic [N-1:0] eg8;
    req   = '0;
    mode  = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("reset_grant", int'(grant), 0);
    check("reset_id", int'(grant_id), 0);
    check("reset_timeout", int'(timeout), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // Fixed priority with back-to-back handover on release.
    cyc(8'hA4, 1'b0, 8'h04, 3'd2, 1'b0);
    cyc(8'hA4, 1'b0, 8'h04, 3'd2, 1'b0);
    cyc(8'hA0, 1'b0, 8'h20, 3'd5, 1'b0);
    cyc(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
    cyc(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

    // Asynchronous reset in the middle of a grant.
    cyc(8'hFF, 1'b0, 8'h01, 3'd0, 1'b0);
    #4 reset = 1'b0;
    #1;
    check("async_rst_grant", int'(grant), 0);
    check("async_rst_id", int'(grant_id), 0);
    check("async_rst_valid", int'(grant_valid), 0);
    check("async_rst_timeout", int'(timeout), 0);
    repeat (2) @(posedge clk);
    check("rst_held_grant", int'(grant), 0);
    #2 reset = 1'b1;

    // Round-robin from reset: first grant to 0, then each owner drops for a cycle.
    cyc(8'hFF, 1'b1, 8'h01, 3'd0, 1'b0);
    for (int i = 0; i < N; i++) begin
      r8 = 8'hFF;
      r8[i] = 1'b0;
      eg8 = '0;
      eg8[(i + 1) % N] = 1'b1;
      cyc(r8, 1'b1, eg8, IDW'((i + 1) % N), 1'b0);
    end
    cyc(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
    cyc(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

    // Two competing holders alternate every MAX_HOLD cycles.
    for (int c = 0; c < MH; c++) cyc(8'h28, 1'b0, 8'h08, 3'd3, 1'b0);
    for (int c = 0; c < MH; c++) cyc(8'h28, 1'b0, 8'h20, 3'd5, c == 0);
    for (int c = 0; c < MH; c++) cyc(8'h28, 1'b0, 8'h08, 3'd3, c == 0);
    cyc(8'h28, 1'b0, 8'h20, 3'd5, 1'b1);
    cyc(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
    cyc(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

    // Lone holder: one empty cycle with TIMEOUT, then re-granted; release at
    // the count match takes priority over pre-emption.
    for (int c = 0; c < MH; c++) cyc(8'h02, 1'b0, 8'h02, 3'd1, 1'b0);
    cyc(8'h02, 1'b0, 8'h00, 3'd0, 1'b1);
    for (int c = 0; c < MH; c++) cyc(8'h02, 1'b0, 8'h02, 3'd1, 1'b0);
    cyc(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
    cyc(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

    // Release coincident with count match hands over without TIMEOUT.
    for (int c = 0; c < MH; c++) cyc(8'h0A, 1'b0, 8'h02, 3'd1, 1'b0);
    cyc(8'h08, 1'b0, 8'h08, 3'd3, 1'b0);
    cyc(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
    cyc(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

    // Mode switch while 6 owns: grant kept, next pick is round-robin from 7.
    cyc(8'h40, 1'b0, 8'h40, 3'd6, 1'b0);
    cyc(8'hC1, 1'b1, 8'h40, 3'd6, 1'b0);
    cyc(8'h81, 1'b1, 8'h80, 3'd7, 1'b0);
    cyc(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_arb.md
# param_arb

Parametrised N-way bus arbiter. It is the next generation of the team's 8-way priority-encoder arbiter, generalised in requester count, with run-time selection between fixed-priority and round-robin modes and an optional maximum-hold timeout that pre-empts a stalled owner. It sits between the `req_dev` requesters and the shared resource, and is driven through the arbitration interface in the top-level bench.

## Interface
Parameters:
- `N`, 8: number of requesters, 2..32.
- `MAX_HOLD`, 16: maximum consecutive grant cycles per owner; 0 disables the timeout.
- `IDW`, `$clog2(N)`: width of `GRANT_ID`.

Ports:
- `CLK`, in, 1: single clock; all state updates on the rising edge.
- `RESET`, in, 1: asynchronous, active-low reset.
- `REQ`, in, N: request lines; `REQ[i]` is held high for as long as requester i wants the resource.
- `MODE`, in, 1: 0 selects fixed priority (index 0 highest); 1 selects round-robin.
- `GRANT`, out, N: one-hot or all-zero grant, registered.
- `GRANT_VALID`, out, 1: equals OR of `GRANT`.
- `GRANT_ID`, out, IDW: binary index of the current owner; 0 when no grant.
- `TIMEOUT`, out, 1: one-cycle pulse on the cycle following a pre-emption.

## Operation
- States:
  - IDLE: no owner.
  - OWNED: one-hot grant held.
- Arbitration at an edge uses the candidate set = `REQ` minus any masked index.
  - Fixed mode: the lowest set index wins.
  - Round-robin mode: search from `LAST+1` upward, wrapping modulo N; the first set index wins.
- `LAST` updates to the winner on every new grant. It is never changed by a timeout alone.
- `MODE` is sampled only at arbitration edges. A mode change never disturbs a grant in progress.
- IDLE:
  - If the candidate set is non-empty, grant the winner, set `HOLD_CNT`=1, go to OWNED.
  - Otherwise stay in IDLE.
- OWNED, with owner o:
  - If `REQ[o]`=0: release. Arbitrate the same edge with o masked. If there is a winner, grant it directly (back-to-back, no gap cycle). Otherwise go to IDLE.
  - Else if `MAX_HOLD`≠0 and `HOLD_CNT`==`MAX_HOLD`: pre-empt. Arbitrate with o masked; assert `TIMEOUT` next cycle. If there is no other candidate, go to IDLE for exactly one cycle. o is eligible again at the following edge.
  - Else: `HOLD_CNT`++ and keep `GRANT`.
- `HOLD_CNT` width is `$clog2(MAX_HOLD+1)`. It never exceeds `MAX_HOLD` and never wraps.
- At most one `GRANT` bit is ever set. `GRANT_ID` and `GRANT_VALID` are always consistent with `GRANT` in the same cycle.
- Requests from non-owners arriving while OWNED are ignored until the next arbitration edge. No request latching: a request that drops before arbitration is lost.

## Timing
- Reset (`RESET`=0, asynchronous, takes effect immediately, including mid-grant):
  - `GRANT`=0, `GRANT_VALID`=0, `GRANT_ID`=0, `TIMEOUT`=0.
  - State=IDLE, `HOLD_CNT`=0, `LAST`=N-1, so round-robin starts at index 0.
- First arbitration occurs at the first rising edge after `RESET` deasserts.
- Request-to-grant latency from IDLE: `REQ` seen at edge k, `GRANT` high after edge k. That is 1 cycle.
- Release: `REQ[o]` low at edge k drops `GRANT[o]` after edge k. The next owner's grant appears after the same edge k.
- Hold: with a continuously requesting owner and competing requests, `GRANT[o]` is high for exactly `MAX_HOLD` cycles. `TIMEOUT` is high for the 1 cycle after the pre-empting edge, coincident with the new owner's first grant cycle.
- Simultaneous owner release and timeout-count match at the same edge: release takes priority and `TIMEOUT` stays 0.

## Test plan
- Reset: drive `RESET`=0 mid-grant with `REQ`=8'hFF → `GRANT`=0, `GRANT_ID`=0 and `TIMEOUT`=0 immediately, without waiting for `CLK`. After release with `MODE`=1, the first grant goes to index 0.
- Fixed priority (N=8, `MODE`=0): `REQ`=8'b1010_0100 at edge k → `GRANT`=8'b0000_0100 and `GRANT_ID`=2 after k. Drop `REQ[2]` at edge m → `GRANT`=8'b0010_0000 and `GRANT_ID`=5 after m, with no gap cycle.
- Round-robin (`MODE`=1): all 8 requesting; each owner drops `REQ` for 1 cycle after receiving its grant → grant order 0,1,2,…,7,0.
- Timeout (`MAX_HOLD`=4, `MODE`=0): `REQ[3]` and `REQ[5]` held high → `GRANT[3]` for 4 cycles, then `GRANT[5]` for 4 cycles with a `TIMEOUT` pulse on its first cycle, then `GRANT[3]` again. The pattern repeats.
- Single-owner timeout (`MAX_HOLD`=4): only `REQ[1]` high → 4 cycles of `GRANT[1]`, then one cycle with `GRANT`=0 and `TIMEOUT`=1, then `GRANT[1]` again for 4 cycles.
- Mode switch: toggle `MODE` 0→1 while index 6 owns → the grant is unaffected. The next arbitration uses round-robin from `LAST`+1=7.
